// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage drives the address; the memory answers combinationally.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register, and saturating stall/flush performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0004,
  parameter int          CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PC_Wr_en,
  input  logic              IF_ID_Wr_en,
  input  logic              IF_ID_flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic              jr,
  input  logic [31:0]       jr_target,
  input  logic              exception,
  if_stage_if.master        imem,
  output logic [31:0]       IF_ID_Instruction,
  output logic [31:0]       IF_ID_PC_plus4,
  output logic              IF_ID_valid,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_ONE;
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [31:0]      pc_plus4;
  logic             bubble;

  assign pc_plus4 = pc_q + 32'd4;
  assign bubble   = exception | IF_ID_flush;

  // Exception and taken branch override a stall: the stalled ID instruction
  // is squashed, so nothing is lost by redirecting. ID-stage redirects must
  // wait until the stall clears so the jump itself is not lost.
  always_comb begin
    pc_d = pc_q;
    if (exception) begin
      pc_d = EXC_VECTOR;
    end else if (branch_taken) begin
      pc_d = word_align(branch_target);
    end else if (PC_Wr_en) begin
      if (jr) begin
        pc_d = word_align(jr_target);
      end else if (jump) begin
        pc_d = word_align(jump_target);
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // A bubble beats a simultaneous hold; PC+4 still tracks the squashed slot.
  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble) begin
      inst_d  = 32'h0000_0000;
      pc4_d   = pc_plus4;
      valid_d = 1'b0;
    end else if (IF_ID_Wr_en) begin
      inst_d  = imem.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bubble) begin
      flush_d = sat_inc(flush_q);
    end else if (!IF_ID_Wr_en) begin
      stall_d = sat_inc(stall_q);
    end
  end

  // IF -> ID boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign imem.imem_addr    = pc_q;
  assign IF_ID_Instruction = inst_q;
  assign IF_ID_PC_plus4    = pc4_q;
  assign IF_ID_valid       = valid_q;
  assign stall_count       = stall_q;
  assign flush_count       = flush_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random hazard/redirect
// traffic, all checked against a behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC    = 32'h8000_0004;
  localparam int          SMALL_W = 3;
  localparam int          SMALL_MAX = 7;

  logic        clk;
  logic        reset_n;
  logic        PC_Wr_en, IF_ID_Wr_en, IF_ID_flush;
  logic        branch_taken, jump, jr, exception;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] IF_ID_Instruction, IF_ID_PC_plus4;
  logic        IF_ID_valid;
  logic [31:0] stall_count, flush_count;
  logic [31:0] s_inst, s_pc4;
  logic        s_valid;
  logic [SMALL_W-1:0] s_stall, s_flush;

  if_stage_if bus ();
  if_stage_if bus_s ();

  assign bus.imem_rdata   = bus.imem_addr + 32'h100;
  assign bus_s.imem_rdata = bus_s.imem_addr + 32'h100;

  if_stage #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en),
    .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
    .exception(exception), .imem(bus.master), .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC_plus4(IF_ID_PC_plus4), .IF_ID_valid(IF_ID_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  if_stage #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC), .CNT_W(SMALL_W)) dut_s (
    .clk(clk), .reset_n(reset_n), .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en),
    .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
    .exception(exception), .imem(bus_s.master), .IF_ID_Instruction(s_inst),
    .IF_ID_PC_plus4(s_pc4), .IF_ID_valid(s_valid),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_pc4;
  logic        m_valid;
  longint      m_stall, m_flush, m_stall_s, m_flush_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inst = 0; m_pc4 = 0; m_valid = 0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
  endtask

  // One rising edge of the fetch stage, from the rules directly.
  task automatic model_edge();
    logic [31:0] seq, nxt;
    logic        squash;
    seq    = m_pc + 32'd4;
    squash = exception || IF_ID_flush;
    if (exception)                nxt = EXC;
    else if (branch_taken)        nxt = branch_target & ~32'd3;
    else if (PC_Wr_en && jr)      nxt = jr_target & ~32'd3;
    else if (PC_Wr_en && jump)    nxt = jump_target & ~32'd3;
    else if (PC_Wr_en)            nxt = seq;
    else                          nxt = m_pc;
    if (squash) begin
      m_inst = 0; m_valid = 0; m_pc4 = seq;
      if (m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_flush_s < SMALL_MAX)   m_flush_s++;
    end else if (IF_ID_Wr_en) begin
      m_inst = m_pc + 32'h100; m_valid = 1; m_pc4 = seq;
    end else begin
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_stall_s < SMALL_MAX)   m_stall_s++;
    end
    m_pc = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  bus.imem_addr, m_pc);
    chk({tag, ".inst"},  IF_ID_Instruction, m_inst);
    chk({tag, ".pc4"},   IF_ID_PC_plus4, m_pc4);
    chk({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, m_valid});
    chk({tag, ".stall"}, stall_count, m_stall[31:0]);
    chk({tag, ".flush"}, flush_count, m_flush[31:0]);
    chk({tag, ".stall_s"}, {29'd0, s_stall}, m_stall_s[31:0]);
    chk({tag, ".flush_s"}, {29'd0, s_flush}, m_flush_s[31:0]);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    PC_Wr_en = 1; IF_ID_Wr_en = 1; IF_ID_flush = 0;
    branch_taken = 0; jump = 0; jr = 0; exception = 0;
    branch_target = 0; jump_target = 0; jr_target = 0;
  endtask

  initial begin
    logic [31:0] held;
    idle();
    reset_n = 0;
    model_reset();
    #2;
    check_all("reset");
    #10 reset_n = 1;

    // Free run from reset
    chk("fetch0.addr", bus.imem_addr, 32'h0);
    step("run1");
    chk("run1.inst", IF_ID_Instruction, 32'h100);
    chk("run1.valid", {31'd0, IF_ID_valid}, 32'd1);
    chk("run1.addr", bus.imem_addr, 32'h4);
    step("run2");
    chk("run2.addr", bus.imem_addr, 32'h8);

    // Load-use stall at PC=8
    PC_Wr_en = 0; IF_ID_Wr_en = 0;
    step("stall");
    chk("stall.addr", bus.imem_addr, 32'h8);
    chk("stall.inst", IF_ID_Instruction, 32'h104);
    chk("stall.cnt", stall_count, 32'd1);
    idle();
    step("unstall");
    chk("unstall.inst", IF_ID_Instruction, 32'h108);

    // Taken branch + flush during a stall
    PC_Wr_en = 0; IF_ID_Wr_en = 0; IF_ID_flush = 1;
    branch_taken = 1; branch_target = 32'h40;
    step("brflush");
    chk("brflush.addr", bus.imem_addr, 32'h40);
    chk("brflush.inst", IF_ID_Instruction, 32'h0);
    chk("brflush.valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("brflush.fcnt", flush_count, 32'd1);
    chk("brflush.scnt", stall_count, 32'd1);
    idle();

    // Jump held by a two-cycle stall, then taken with low bits cleared
    held = bus.imem_addr;
    jump = 1; jump_target = 32'h0000_0203; PC_Wr_en = 0; IF_ID_Wr_en = 0;
    step("jhold1");
    chk("jhold1.addr", bus.imem_addr, held);
    step("jhold2");
    chk("jhold2.addr", bus.imem_addr, held);
    PC_Wr_en = 1; IF_ID_Wr_en = 1;
    step("jgo");
    chk("jgo.addr", bus.imem_addr, 32'h200);
    idle();

    // Exception beats a simultaneous branch
    exception = 1; branch_taken = 1; branch_target = 32'h1000;
    step("exc");
    chk("exc.addr", bus.imem_addr, EXC);
    chk("exc.valid", {31'd0, IF_ID_valid}, 32'd0);
    idle();

    // PC wrap at the top of the address space
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    step("towrap");
    idle();
    step("wrap");
    chk("wrap.addr", bus.imem_addr, 32'h0);
    chk("wrap.pc4", IF_ID_PC_plus4, 32'h0);
    chk("wrap.inst", IF_ID_Instruction, 32'h0000_00FC);

    // Saturate the narrow instance's counters
    IF_ID_Wr_en = 0;
    for (int i = 0; i < 9; i++) step("satstall");
    chk("sat.stall_s", {29'd0, s_stall}, 32'd7);
    IF_ID_Wr_en = 1; IF_ID_flush = 1;
    for (int i = 0; i < 8; i++) step("satflush");
    chk("sat.flush_s", {29'd0, s_flush}, 32'd7);
    idle();

    // Asynchronous reset mid-cycle during a stall
    PC_Wr_en = 0; IF_ID_Wr_en = 0;
    @(posedge clk);
    model_edge();
    #3 reset_n = 0;
    #1;
    model_reset();
    check_all("areset");
    chk("areset.addr", bus.imem_addr, RST_PC);
    chk("areset.scnt", stall_count, 32'd0);
    #10;
    check_all("areset_hold");
    @(negedge clk);
    reset_n = 1;
    idle();
    step("postrst");
    chk("postrst.inst", IF_ID_Instruction, 32'h100);

    // Random hazard and redirect traffic
    for (int i = 0; i < 400; i++) begin
      exception     = ($urandom_range(15) == 0);
      branch_taken  = ($urandom_range(7) == 0);
      jump          = ($urandom_range(7) == 0);
      jr            = ($urandom_range(7) == 0);
      IF_ID_flush   = ($urandom_range(7) == 0);
      PC_Wr_en      = ($urandom_range(3) != 0);
      IF_ID_Wr_en   = ($urandom_range(3) != 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      jr_target     = $urandom;
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
